// File: rtl/dmem_pkg.sv
// Shared types and defaults for the data-memory controller: FSM state encoding,
// MMIO window base, timeout default and the word returned on an MMIO timeout.
package dmem_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  localparam logic [31:0] MMIO_BASE_DEF   = 32'hAAAAA000;
  localparam logic [31:0] MMIO_ERR_WORD   = 32'hDEADBEEF;
  localparam int unsigned TIMEOUT_CYC_DEF = 255;

endpackage

// File: rtl/dmem_bram.sv
// Single-port word RAM with four byte-lane write enables and a registered read
// port, written in the template synthesis tools map onto block RAM.
module dmem_bram #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          i_en,
  input  logic [3:0]    i_we,
  input  logic [AW-1:0] i_addr,
  input  logic [31:0]   i_wdata,
  output logic [31:0]   o_rdata
);

  logic [31:0] r_mem [0:DEPTH_WORDS-1];
  logic [31:0] r_rdata;

  // Read-first: a same-cycle write does not show on the read port.
  always_ff @(posedge clk) begin
    if (i_en) begin
      for (int i = 0; i < 4; i++) begin
        if (i_we[i]) r_mem[i_addr][8*i +: 8] <= i_wdata[8*i +: 8];
      end
      r_rdata <= r_mem[i_addr];
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller: routes pipeline loads/stores to a local RAM or to a
// stalling MMIO handshake. Define DMEM_MMIO_TIMEOUT_EN to bound the MMIO wait.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter logic [31:0] MMIO_BASE   = MMIO_BASE_DEF,
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic        clk,
  input  logic        Rst,
  input  logic        dbg,
  input  logic        mem_wea,
  input  logic        mem_rea,
  input  logic [3:0]  mem_en,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_din,
  output logic [31:0] mem_dout,
  output logic        mem_hold,
  output logic        mmio_req,
  output logic        mmio_we,
  output logic [11:0] mmio_addr,
  output logic [31:0] mmio_wdata,
  input  logic        mmio_ack,
  input  logic [31:0] mmio_rdata
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  function automatic logic [31:0] rotl_bytes(input logic [31:0] d, input logic [1:0] sh);
    logic [31:0] r;
    case (sh)
      2'd0:    r = d;
      2'd1:    r = {d[23:0], d[31:24]};
      2'd2:    r = {d[15:0], d[31:16]};
      default: r = {d[7:0],  d[31:8]};
    endcase
    return r;
  endfunction

  state_t      r_state;
  state_t      w_next;
  logic        w_is_mmio;
  logic        w_hold;
  logic        w_req;
  logic        w_start;
  logic        w_timeout;
  logic [3:0]  w_ram_we;
  logic [31:0] w_ram_rdata;
  logic        r_mmio_we;
  logic [11:0] r_mmio_addr;
  logic [31:0] r_mmio_wdata;
  logic [31:0] r_mmio_rdata;
  logic        r_src_mmio;

  assign w_is_mmio = (mem_addr[31:12] == MMIO_BASE[31:12]) && (mem_wea || mem_rea);

  always_ff @(posedge clk or posedge Rst) begin
    if (Rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      ST_IDLE: if (w_is_mmio && !dbg)       w_next = ST_WAIT;
      ST_WAIT: if (mmio_ack || w_timeout)   w_next = ST_DONE;
      ST_DONE:                              w_next = ST_IDLE;
      default:                              w_next = ST_IDLE;
    endcase
  end

  // Stall starts combinationally in the request cycle so the pipeline never
  // advances past an MMIO access before the handshake is launched.
  always_comb begin
    w_hold = 1'b0;
    w_req  = 1'b0;
    case (r_state)
      ST_IDLE: w_hold = w_is_mmio && !dbg;
      ST_WAIT: begin
        w_hold = 1'b1;
        w_req  = 1'b1;
      end
      default: ;
    endcase
    if (Rst) begin
      w_hold = 1'b0;
      w_req  = 1'b0;
    end
  end

  assign w_start = (r_state == ST_IDLE) && (w_next == ST_WAIT);

  always_ff @(posedge clk or posedge Rst) begin
    if (Rst) begin
      r_mmio_we    <= 1'b0;
      r_mmio_addr  <= '0;
      r_mmio_wdata <= '0;
    end else if (w_start) begin
      r_mmio_we    <= mem_wea;
      r_mmio_addr  <= mem_addr[11:0];
      r_mmio_wdata <= mem_din;
    end
  end

  always_ff @(posedge clk or posedge Rst) begin
    if (Rst)                                     r_mmio_rdata <= '0;
    else if (r_state == ST_WAIT && mmio_ack)     r_mmio_rdata <= mmio_rdata;
    else if (r_state == ST_WAIT && w_timeout)    r_mmio_rdata <= MMIO_ERR_WORD;
  end

`ifdef DMEM_MMIO_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT_CYC + 1);
  logic [CW-1:0] r_to_cnt;

  always_ff @(posedge clk or posedge Rst) begin
    if (Rst)                      r_to_cnt <= '0;
    else if (r_state != ST_WAIT)  r_to_cnt <= '0;
    else                          r_to_cnt <= r_to_cnt + 1'b1;
  end

  assign w_timeout = (r_state == ST_WAIT) && (r_to_cnt == CW'(TIMEOUT_CYC - 1));
`else
  logic [31:0] w_unused_timeout;
  assign w_unused_timeout = 32'(TIMEOUT_CYC);
  assign w_timeout        = 1'b0;
`endif

  // Reset selects the cleared capture register so mem_dout reads zero.
  always_ff @(posedge clk or posedge Rst) begin
    if (Rst)          r_src_mmio <= 1'b1;
    else if (!w_hold) r_src_mmio <= w_is_mmio;
  end

  assign w_ram_we = mem_en & {4{mem_wea && !dbg && !w_hold && !w_is_mmio}};

  dmem_bram #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_bram (
    .clk     (clk),
    .i_en    (!w_hold),
    .i_we    (w_ram_we),
    .i_addr  (mem_addr[AW+1:2]),
    .i_wdata (rotl_bytes(mem_din, mem_addr[1:0])),
    .o_rdata (w_ram_rdata)
  );

  assign mem_dout   = r_src_mmio ? r_mmio_rdata : w_ram_rdata;
  assign mem_hold   = w_hold;
  assign mmio_req   = w_req;
  assign mmio_we    = r_mmio_we;
  assign mmio_addr  = r_mmio_addr;
  assign mmio_wdata = r_mmio_wdata;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Self-checking bench for dmem_ctrl: byte-level RAM model plus scripted MMIO
// handshakes, reset-in-wait and (with DMEM_MMIO_TIMEOUT_EN) timeout behaviour.
module tb_dmem_ctrl;

  localparam int TO = 8;

  logic        clk = 1'b0;
  logic        Rst, dbg, mem_wea, mem_rea;
  logic [3:0]  mem_en;
  logic [31:0] mem_addr, mem_din, mem_dout;
  logic        mem_hold, mmio_req, mmio_we;
  logic [11:0] mmio_addr;
  logic [31:0] mmio_wdata;
  logic        mmio_ack;
  logic [31:0] mmio_rdata;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] mdl [0:1023];

  dmem_ctrl #(.DEPTH_WORDS(1024), .MMIO_BASE(32'hAAAAA000), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .Rst(Rst), .dbg(dbg), .mem_wea(mem_wea), .mem_rea(mem_rea),
    .mem_en(mem_en), .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout),
    .mem_hold(mem_hold), .mmio_req(mmio_req), .mmio_we(mmio_we), .mmio_addr(mmio_addr),
    .mmio_wdata(mmio_wdata), .mmio_ack(mmio_ack), .mmio_rdata(mmio_rdata)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic idle_inputs();
    mem_wea = 1'b0; mem_rea = 1'b0; mem_en = 4'b0000;
  endtask

  task automatic ram_store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] en);
    mem_wea = 1'b1; mem_rea = 1'b0; mem_addr = a; mem_din = d; mem_en = en;
    tick();
    idle_inputs();
  endtask

  task automatic ram_load(input logic [31:0] a, output logic [31:0] q, output logic h);
    mem_rea = 1'b1; mem_wea = 1'b0; mem_en = 4'b0000; mem_addr = a;
    @(negedge clk); h = mem_hold;
    tick();
    idle_inputs();
    @(negedge clk); q = mem_dout;
    tick();
  endtask

  // Model: byte lane i receives din byte ((i - offset) mod 4).
  function automatic void mdl_store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] en);
    int w;
    int off;
    w   = int'(a[11:2]);
    off = int'(a[1:0]);
    for (int i = 0; i < 4; i++)
      if (en[i]) mdl[w][8*i +: 8] = d[8*((i - off) & 3) +: 8];
  endfunction

  task automatic mmio_access(input logic we, input logic [31:0] a, input logic [31:0] d,
                             input int ack_after, input logic [31:0] rdata,
                             output int hold_cyc, output int req_cyc, output int rises,
                             output logic [11:0] s_addr, output logic s_we,
                             output logic [31:0] s_wdata, output logic [31:0] dout, output logic ok);
    logic prev;
    mem_wea = we; mem_rea = !we; mem_en = we ? 4'hF : 4'h0; mem_addr = a; mem_din = d;
    hold_cyc = 0; req_cyc = 0; rises = 0; prev = 1'b0; ok = 1'b0;
    s_addr = '0; s_we = 1'b0; s_wdata = '0; dout = '0;
    for (int c = 0; c < 600 && !ok; c++) begin
      @(negedge clk);
      if (mmio_req && !prev) rises++;
      prev = mmio_req;
      if (mmio_req) begin
        req_cyc++;
        s_addr = mmio_addr; s_we = mmio_we; s_wdata = mmio_wdata;
        if (ack_after != 0 && req_cyc == ack_after) begin
          mmio_ack = 1'b1; mmio_rdata = rdata;
        end
      end
      if (mem_hold) hold_cyc++;
      else if (hold_cyc > 0) ok = 1'b1;
      tick();
      mmio_ack = 1'b0;
    end
    idle_inputs();
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (c == 0) dout = mem_dout;
      if (mmio_req && !prev) rises++;
      prev = mmio_req;
      tick();
    end
  endtask

  task automatic test_reset();
    Rst = 1'b1; dbg = 1'b0; idle_inputs(); mem_addr = '0; mem_din = '0;
    mmio_ack = 1'b0; mmio_rdata = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_tests++; if (mem_hold !== 1'b0) begin n_fail++; $display("FAIL reset_hold got %0h want 0", mem_hold); end
    n_tests++; if (mmio_req !== 1'b0) begin n_fail++; $display("FAIL reset_req got %0h want 0", mmio_req); end
    n_tests++; if (mmio_we !== 1'b0) begin n_fail++; $display("FAIL reset_we got %0h want 0", mmio_we); end
    n_tests++; if (mmio_addr !== 12'h000) begin n_fail++; $display("FAIL reset_addr got %0h want 0", mmio_addr); end
    n_tests++; if (mmio_wdata !== 32'h0) begin n_fail++; $display("FAIL reset_wdata got %0h want 0", mmio_wdata); end
    n_tests++; if (mem_dout !== 32'h0) begin n_fail++; $display("FAIL reset_dout got %0h want 0", mem_dout); end
    tick();
    Rst = 1'b0;
    tick();
  endtask

  task automatic test_ram_basic();
    logic [31:0] q;
    logic h;
    ram_store(32'h10, 32'h11223344, 4'b1111); mdl_store(32'h10, 32'h11223344, 4'b1111);
    ram_load(32'h10, q, h);
    n_tests++; if (q !== 32'h11223344) begin n_fail++; $display("FAIL sw_lw got %08h want 11223344", q); end
    n_tests++; if (h !== 1'b0) begin n_fail++; $display("FAIL ram_hold got %0h want 0", h); end
    ram_store(32'h12, 32'h000000AB, 4'b0100); mdl_store(32'h12, 32'h000000AB, 4'b0100);
    ram_load(32'h10, q, h);
    n_tests++; if (q !== 32'h11AB3344) begin n_fail++; $display("FAIL sb_merge got %08h want 11ab3344", q); end
    dbg = 1'b1;
    ram_store(32'h10, 32'hFFFFFFFF, 4'b1111);
    dbg = 1'b0;
    ram_load(32'h10, q, h);
    n_tests++; if (q !== 32'h11AB3344) begin n_fail++; $display("FAIL dbg_blocks_store got %08h want 11ab3344", q); end
    ram_store(32'h14, 32'h0, 4'b1111); mdl_store(32'h14, 32'h0, 4'b1111);
    ram_store(32'h17, 32'h0000BEEF, 4'b1001); mdl_store(32'h17, 32'h0000BEEF, 4'b1001);
    ram_load(32'h14, q, h);
    n_tests++; if (q !== 32'hEF0000BE) begin n_fail++; $display("FAIL sh_wrap got %08h want ef0000be", q); end
    ram_load(32'h3010, q, h);
    n_tests++; if (q !== 32'h11AB3344) begin n_fail++; $display("FAIL addr_alias got %08h want 11ab3344", q); end
  endtask

  task automatic test_ram_random();
    logic [31:0] q, a, d;
    logic [3:0]  base, en;
    logic [7:0]  m8;
    logic h;
    int w, off;
    for (int i = 0; i < 32; i++) begin
      d = $urandom; a = 32'(i) << 2;
      ram_store(a, d, 4'b1111); mdl_store(a, d, 4'b1111);
    end
    for (int n = 0; n < 80; n++) begin
      w   = int'($urandom_range(0, 31));
      off = int'($urandom_range(0, 3));
      a   = (32'($urandom_range(0, 3)) << 12) | (32'(w) << 2) | 32'(off);
      if ($urandom_range(0, 9) < 6) begin
        case ($urandom_range(0, 2))
          0:       base = 4'b1111;
          1:       base = 4'b0011;
          default: base = 4'b0001;
        endcase
        m8 = {base, base} << off;
        en = m8[7:4];
        d  = $urandom;
        ram_store(a, d, en); mdl_store(a, d, en);
      end else begin
        ram_load(a, q, h);
        n_tests++; if (q !== mdl[w] || h !== 1'b0)
          begin n_fail++; $display("FAIL rand_load addr %08h got %08h hold %0h want %08h hold 0", a, q, h, mdl[w]); end
      end
    end
  endtask

  task automatic test_mmio_read();
    int hc, rc, rs;
    logic [11:0] sa;
    logic sw, ok;
    logic [31:0] swd, q;
    mmio_access(1'b0, 32'hAAAAA008, 32'h0, 3, 32'h0000005A, hc, rc, rs, sa, sw, swd, q, ok);
    n_tests++; if (ok !== 1'b1) begin n_fail++; $display("FAIL mmio_rd_complete got %0h want 1", ok); end
    n_tests++; if (hc != 4) begin n_fail++; $display("FAIL mmio_rd_hold_cycles got %0d want 4", hc); end
    n_tests++; if (rs != 1) begin n_fail++; $display("FAIL mmio_rd_requests got %0d want 1", rs); end
    n_tests++; if (sa !== 12'h008 || sw !== 1'b0) begin n_fail++; $display("FAIL mmio_rd_addr got %03h we %0h want 008 we 0", sa, sw); end
    n_tests++; if (q !== 32'h5A) begin n_fail++; $display("FAIL mmio_rd_dout got %08h want 0000005a", q); end
  endtask

  task automatic test_stray_ack();
    int bad;
    bad = 0;
    mmio_ack = 1'b1; mmio_rdata = 32'h0BAD0BAD;
    tick();
    mmio_ack = 1'b0;
    @(negedge clk); if (mem_hold !== 1'b0 || mmio_req !== 1'b0) bad++;
    dbg = 1'b1; mem_rea = 1'b1; mem_addr = 32'hAAAAA010;
    @(negedge clk); if (mem_hold !== 1'b0 || mmio_req !== 1'b0) bad++;
    tick();
    idle_inputs(); dbg = 1'b0;
    @(negedge clk);
    n_tests++; if (bad != 0) begin n_fail++; $display("FAIL stray_ack_ctrl got %0d bad cycles want 0", bad); end
    n_tests++; if (mem_dout !== 32'h5A) begin n_fail++; $display("FAIL stray_ack_data got %08h want 0000005a", mem_dout); end
    tick();
  endtask

  task automatic test_mmio_dbg();
    int hc, rc, rs, seen;
    logic [11:0] sa;
    logic sw, ok;
    logic [31:0] swd, q, d;
    d = $urandom; seen = 0;
    dbg = 1'b1; mem_wea = 1'b1; mem_en = 4'hF; mem_addr = 32'hAAAAA004; mem_din = d;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk); if (mmio_req !== 1'b0 || mem_hold !== 1'b0) seen++;
      tick();
    end
    dbg = 1'b0;
    n_tests++; if (seen != 0) begin n_fail++; $display("FAIL dbg_no_req got %0d active cycles want 0", seen); end
    mmio_access(1'b1, 32'hAAAAA004, d, 2, 32'h0, hc, rc, rs, sa, sw, swd, q, ok);
    n_tests++; if (rs != 1 || ok !== 1'b1) begin n_fail++; $display("FAIL dbg_release_req got %0d ok %0h want 1 ok 1", rs, ok); end
    n_tests++; if (sw !== 1'b1 || sa !== 12'h004 || swd !== d)
      begin n_fail++; $display("FAIL mmio_wr_fields got we %0h addr %03h data %08h want we 1 addr 004 data %08h", sw, sa, swd, d); end
    n_tests++; if (hc != 3) begin n_fail++; $display("FAIL mmio_wr_hold got %0d want 3", hc); end
  endtask

  task automatic test_rst_in_wait();
    int bad;
    logic [31:0] q;
    logic h;
    bad = 0;
    mem_rea = 1'b1; mem_addr = 32'hAAAAA00C;
    for (int c = 0; c < 10 && mmio_req !== 1'b1; c++) begin
      @(negedge clk);
      if (mmio_req !== 1'b1) tick();
    end
    n_tests++; if (mmio_req !== 1'b1) begin n_fail++; $display("FAIL rst_wait_entry got %0h want 1", mmio_req); end
    Rst = 1'b1;
    #1;
    n_tests++; if (mem_hold !== 1'b0 || mmio_req !== 1'b0)
      begin n_fail++; $display("FAIL rst_abort got hold %0h req %0h want 0 0", mem_hold, mmio_req); end
    n_tests++; if (mem_dout !== 32'h0 || mmio_addr !== 12'h0)
      begin n_fail++; $display("FAIL rst_clear got dout %08h addr %03h want 0 0", mem_dout, mmio_addr); end
    tick();
    idle_inputs(); Rst = 1'b0;
    tick();
    @(negedge clk); mmio_ack = 1'b1; mmio_rdata = 32'h77777777;
    tick();
    mmio_ack = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk); if (mem_hold !== 1'b0 || mmio_req !== 1'b0) bad++;
      tick();
    end
    n_tests++; if (bad != 0) begin n_fail++; $display("FAIL rst_late_ack got %0d active cycles want 0", bad); end
    ram_load(32'h10, q, h);
    n_tests++; if (q !== mdl[4] || h !== 1'b0) begin n_fail++; $display("FAIL post_rst_ram got %08h want %08h", q, mdl[4]); end
  endtask

  task automatic test_timeout();
    int hc, rc, rs;
    logic [11:0] sa;
    logic sw, ok;
    logic [31:0] swd, q;
`ifdef DMEM_MMIO_TIMEOUT_EN
    mmio_access(1'b0, 32'hAAAAA020, 32'h0, 0, 32'h0, hc, rc, rs, sa, sw, swd, q, ok);
    n_tests++; if (ok !== 1'b1 || rc != TO || hc != TO + 1)
      begin n_fail++; $display("FAIL timeout_len got ok %0h wait %0d hold %0d want 1 %0d %0d", ok, rc, hc, TO, TO + 1); end
    n_tests++; if (q !== 32'hDEADBEEF) begin n_fail++; $display("FAIL timeout_data got %08h want deadbeef", q); end
`else
    mmio_access(1'b0, 32'hAAAAA020, 32'h0, 300, 32'hCAFE0123, hc, rc, rs, sa, sw, swd, q, ok);
    n_tests++; if (ok !== 1'b1 || rc != 300 || hc != 301)
      begin n_fail++; $display("FAIL long_wait got ok %0h wait %0d hold %0d want 1 300 301", ok, rc, hc); end
    n_tests++; if (q !== 32'hCAFE0123) begin n_fail++; $display("FAIL long_wait_data got %08h want cafe0123", q); end
`endif
  endtask

  initial begin
    test_reset();
    test_ram_basic();
    test_ram_random();
    test_mmio_read();
    test_stray_ack();
    test_mmio_dbg();
    test_rst_in_wait();
    test_timeout();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
